inst_axi_responder: RTL and testbench
=====================================

# inst_axi_responder

Instruction-fetch responder on the cache side of the fetch request protocol. It accepts a single-word fetch request (`inst_ren_i`, `inst_addr_i`), runs one single-beat AXI4 read on the instruction port, and returns the word with a one-cycle `inst_ok_o` pulse plus `inst_valid_o`. The fetch stage treats `inst_ren & ~inst_ok` as a stall. `flush_i` cancels a request in flight: the AXI transaction still completes, but its data is discarded.

## Interface
Parameters:
- `ARID`, 4'h0: fixed AXI read ID.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous reset, active-low.
- `inst_ren_i` in 1: fetch request, held until `inst_ok_o` or flush.
- `inst_addr_i` in 32: fetch address.
- `flush_i` in 1: cancel current and pending request.
- `inst_ok_o` out 1: one-cycle response strobe.
- `inst_valid_o` out 1: response carries good data (RRESP == OKAY).
- `inst_rdata_o` out 32: fetched word, valid when `inst_ok_o` = 1.
- `arid` out 4, `araddr` out 32, `arlen` out 8, `arsize` out 3, `arburst` out 2, `arvalid` out 1, `arready` in 1: AXI AR channel.
- `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1: AXI R channel.

## Operation
- Fixed fields: `arid` = ARID, `arlen` = 0, `arsize` = 3'b010, `arburst` = 2'b01. `araddr[1:0]` is forced to 0; address errors are trapped upstream.
- FSM states: IDLE, AR, R, DONE.
  - IDLE: if `inst_ren_i & ~flush_i`, latch the address into `araddr`, set `arvalid` = 1, go to AR.
  - AR: hold `arvalid` and `araddr` stable until `arready`. On `arvalid & arready`, clear `arvalid`, set `rready` = 1, go to R.
  - R: on `rvalid & rready`, clear `rready`. If the cancel flag is clear, latch `rdata` into `inst_rdata_o`, latch `inst_valid_o` = (`rresp` == 2'b00), and go to DONE. If the cancel flag is set, clear it and go to IDLE with no response.
  - DONE: always return to IDLE next cycle.
- Cancel flag:
  - Set by `flush_i` in AR or R.
  - Never drops `arvalid` once raised (AXI rule).
  - Cleared on the R handshake that consumes the cancelled beat.
- `inst_ok_o` = (state == DONE) & ~`flush_i`. This is the only combinational path from an input to an output.
- `rid` and `rlast` are ignored functionally. Assertions check `rid` == ARID and `rlast` == 1.
- At most one outstanding AXI read at any time.

## Timing
- Reset (async assert, sync deassert at the top level) drives these outputs to 0: `arvalid`, `rready`, `araddr`, `inst_rdata_o`, `inst_valid_o`. State goes to IDLE and the cancel flag is cleared. `inst_ok_o` is therefore 0.
- Minimum latency with `arready` = 1 and `rvalid` = 1 immediately:
  - Cycle 0: request accepted.
  - Cycle 1: `arvalid` high, AR handshake.
  - Cycle 2: `rready` high, R handshake.
  - Cycle 3: `inst_ok_o` = 1.
- Back-to-back: the next request is accepted no earlier than the cycle after DONE, i.e. 4 cycles per fetch.
- Flush timing:
  - Flush in IDLE: no request is accepted that cycle.
  - Flush in DONE: suppresses `inst_ok_o` that cycle; the data is dropped.
  - Flush in AR or R, with a new `inst_ren_i` arriving: the new request waits in IDLE until the cancelled beat drains.
- Reset mid-transaction abandons the AXI transfer. The interconnect is reset on the same `aresetn`.
- `inst_rdata_o` and `inst_valid_o` hold their values until the next non-cancelled R handshake.

## Structure
- Shared package `axi_pkg`: AXI constants (burst INCR, size-4B, RESP_OKAY) and the FSM state encoding (2-bit localparams IDLE/AR/R/DONE).
- Flat single module; no sub-module is warranted.

## Test plan
- Basic fetch: `inst_ren_i` = 1 at 0xBFC00000, `arready`/`rvalid` immediate, `rdata` = 0x3C08BFAF → `araddr` = 0xBFC00000 in cycle 1, `inst_ok_o` = 1 in cycle 3 with `inst_rdata_o` = 0x3C08BFAF and `inst_valid_o` = 1.
- AR backpressure: `arready` held low for 5 cycles → `arvalid` and `araddr` stay stable for all 5 cycles; `inst_ok_o` arrives 5 cycles later than in the basic case.
- Bus error: `rresp` = 2'b10 → `inst_ok_o` = 1 and `inst_valid_o` = 0.
- Flush in R: flush while waiting on `rvalid`, then a new request to 0xBFC00380 → the first beat is consumed with no `inst_ok_o`; a second AR with `araddr` = 0xBFC00380 follows, then `inst_ok_o` for it.
- Flush in DONE: `flush_i` = 1 in the DONE cycle → `inst_ok_o` stays 0; the FSM returns to IDLE.
- Reset mid-AR: `aresetn` = 0 while `arvalid` = 1 → `arvalid` = 0 immediately; state is IDLE; after release, a fresh request works normally.

Source files
------------

// File: rtl/inst_axi_responder_pkg.sv
// AXI read-channel constants and FSM state encoding for the instruction-fetch responder.
package inst_axi_responder_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] LEN_SINGLE = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/inst_axi_responder_if.sv
// AXI4 read address/data channels; the responder drives the master side.
interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/inst_axi_responder.sv
// Single-word instruction fetch over one single-beat AXI4 read, with flush cancellation.
//   state | meaning
//   IDLE  | waiting for a fetch request
//   AR    | address presented, waiting for arready
//   R     | waiting for the read beat
//   DONE  | response strobe cycle
module inst_axi_responder
    import inst_axi_responder_pkg::*;
#(
    parameter logic [3:0] ARID = 4'h0
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        inst_ren_i,
    input  logic [31:0] inst_addr_i,
    input  logic        flush_i,
    output logic        inst_ok_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_rdata_o,
    axi_rd_if.master    axi
);

    state_t      state;
    logic        cancel;
    logic        arvalid_q;
    logic [31:0] araddr_q;
    logic        rready_q;
    logic [31:0] rdata_q;
    logic        valid_q;

    assign axi.arid    = ARID;
    assign axi.arlen   = LEN_SINGLE;
    assign axi.arsize  = SIZE_4B;
    assign axi.arburst = BURST_INCR;
    assign axi.arvalid = arvalid_q;
    assign axi.araddr  = araddr_q;
    assign axi.rready  = rready_q;

    assign inst_rdata_o = rdata_q;
    assign inst_valid_o = valid_q;
    assign inst_ok_o    = (state == ST_DONE) && !flush_i;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= ST_IDLE;
            cancel    <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            rdata_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (inst_ren_i && !flush_i) begin
                        araddr_q  <= {inst_addr_i[31:2], 2'b00};
                        arvalid_q <= 1'b1;
                        state     <= ST_AR;
                    end
                end
                ST_AR: begin
                    // arvalid must stay up once raised, so a flush only marks the beat for discard
                    if (flush_i) cancel <= 1'b1;
                    if (arvalid_q && axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= ST_R;
                    end
                end
                ST_R: begin
                    if (flush_i) cancel <= 1'b1;
                    if (rready_q && axi.rvalid) begin
                        rready_q <= 1'b0;
                        // a flush coinciding with the beat also cancels it
                        if (cancel || flush_i) begin
                            cancel <= 1'b0;
                            state  <= ST_IDLE;
                        end else begin
                            rdata_q <= axi.rdata;
                            valid_q <= (axi.rresp == RESP_OKAY);
                            state   <= ST_DONE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (aresetn && axi.rvalid && axi.rready) begin
            assert (axi.rid == ARID);
            assert (axi.rlast);
        end
    end

endmodule

// File: tb/tb_inst_axi_responder.sv
// Directed bench for inst_axi_responder: fetch, backpressure, bus error, flush and reset cases.
module tb_inst_axi_responder;
    logic        aclk;
    logic        aresetn;
    logic        inst_ren_i;
    logic [31:0] inst_addr_i;
    logic        flush_i;
    logic        inst_ok_o;
    logic        inst_valid_o;
    logic [31:0] inst_rdata_o;

    int tests = 0;
    int fails = 0;

    axi_rd_if bus ();

    inst_axi_responder #(.ARID(4'h0)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .inst_ren_i   (inst_ren_i),
        .inst_addr_i  (inst_addr_i),
        .flush_i      (flush_i),
        .inst_ok_o    (inst_ok_o),
        .inst_valid_o (inst_valid_o),
        .inst_rdata_o (inst_rdata_o),
        .axi          (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        aresetn      = 1'b0;
        inst_ren_i   = 1'b0;
        inst_addr_i  = '0;
        flush_i      = 1'b0;
        bus.arready  = 1'b0;
        bus.rvalid   = 1'b0;
        bus.rid      = 4'h0;
        bus.rlast    = 1'b1;
        bus.rresp    = 2'b00;
        bus.rdata    = '0;

        step(); step();
        chk("rst_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rst_rready",  32'(bus.rready), 32'd0);
        chk("rst_araddr",  bus.araddr, 32'd0);
        chk("rst_rdata",   inst_rdata_o, 32'd0);
        chk("rst_valid",   32'(inst_valid_o), 32'd0);
        chk("rst_ok",      32'(inst_ok_o), 32'd0);
        chk("arlen",       32'(bus.arlen), 32'd0);
        chk("arsize",      32'(bus.arsize), 32'd2);
        chk("arburst",     32'(bus.arburst), 32'd1);
        aresetn = 1'b1;
        step();

        // basic fetch
        inst_ren_i  = 1'b1;
        inst_addr_i = 32'hBFC0_0000;
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h3C08_BFAF;
        chk("basic_ok_c0", 32'(inst_ok_o), 32'd0);
        step();
        chk("basic_arvalid_c1", 32'(bus.arvalid), 32'd1);
        chk("basic_araddr_c1",  bus.araddr, 32'hBFC0_0000);
        step();
        chk("basic_rready_c2",  32'(bus.rready), 32'd1);
        chk("basic_arvalid_c2", 32'(bus.arvalid), 32'd0);
        chk("basic_ok_c2",      32'(inst_ok_o), 32'd0);
        step();
        chk("basic_ok_c3",    32'(inst_ok_o), 32'd1);
        chk("basic_rdata_c3", inst_rdata_o, 32'h3C08_BFAF);
        chk("basic_valid_c3", 32'(inst_valid_o), 32'd1);
        inst_ren_i = 1'b0;
        bus.rvalid = 1'b0;
        step();
        chk("basic_ok_c4", 32'(inst_ok_o), 32'd0);

        // AR backpressure, unaligned address gets its low bits cleared
        inst_ren_i  = 1'b1;
        inst_addr_i = 32'h8000_1006;
        bus.arready = 1'b0;
        bus.rdata   = 32'h1111_2222;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_arvalid", 32'(bus.arvalid), 32'd1);
            chk("bp_araddr",  bus.araddr, 32'h8000_1004);
            chk("bp_ok",      32'(inst_ok_o), 32'd0);
            step();
        end
        bus.arready = 1'b1;
        chk("bp_arvalid_c6", 32'(bus.arvalid), 32'd1);
        step();
        chk("bp_rready_c7", 32'(bus.rready), 32'd1);
        chk("bp_ok_c7",     32'(inst_ok_o), 32'd0);
        bus.rvalid = 1'b1;
        step();
        chk("bp_ok_c8",    32'(inst_ok_o), 32'd1);
        chk("bp_rdata_c8", inst_rdata_o, 32'h1111_2222);
        inst_ren_i = 1'b0;
        bus.rvalid = 1'b0;
        step();

        // bus error response
        inst_ren_i  = 1'b1;
        inst_addr_i = 32'hBFC0_0010;
        bus.rvalid  = 1'b1;
        bus.rresp   = 2'b10;
        bus.rdata   = 32'hDEAD_BEEF;
        step(); step(); step();
        chk("err_ok",    32'(inst_ok_o), 32'd1);
        chk("err_valid", 32'(inst_valid_o), 32'd0);
        chk("err_rdata", inst_rdata_o, 32'hDEAD_BEEF);
        inst_ren_i = 1'b0;
        bus.rvalid = 1'b0;
        bus.rresp  = 2'b00;
        step();

        // flush while waiting on the read beat, then a new request
        inst_ren_i  = 1'b1;
        inst_addr_i = 32'hBFC0_0100;
        bus.rdata   = 32'hAAAA_5555;
        step();
        step();
        chk("flr_rready_c2", 32'(bus.rready), 32'd1);
        flush_i     = 1'b1;
        inst_addr_i = 32'hBFC0_0380;
        step();
        flush_i    = 1'b0;
        chk("flr_rready_c3", 32'(bus.rready), 32'd1);
        bus.rvalid = 1'b1;
        step();
        chk("flr_ok_c4",      32'(inst_ok_o), 32'd0);
        chk("flr_rready_c4",  32'(bus.rready), 32'd0);
        chk("flr_arvalid_c4", 32'(bus.arvalid), 32'd0);
        chk("flr_hold_rdata", inst_rdata_o, 32'hDEAD_BEEF);
        chk("flr_hold_valid", 32'(inst_valid_o), 32'd0);
        bus.rvalid = 1'b0;
        step();
        chk("flr_ok_c5",      32'(inst_ok_o), 32'd0);
        chk("flr_arvalid_c5", 32'(bus.arvalid), 32'd1);
        chk("flr_araddr_c5",  bus.araddr, 32'hBFC0_0380);
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        step();
        chk("flr_rready_c6", 32'(bus.rready), 32'd1);
        step();
        chk("flr_ok_c7",    32'(inst_ok_o), 32'd1);
        chk("flr_rdata_c7", inst_rdata_o, 32'h1234_5678);
        chk("flr_valid_c7", 32'(inst_valid_o), 32'd1);
        inst_ren_i = 1'b0;
        bus.rvalid = 1'b0;
        step();

        // flush in the DONE cycle
        inst_ren_i  = 1'b1;
        inst_addr_i = 32'h0000_0100;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'h0BAD_F00D;
        step(); step(); step();
        chk("fld_ok_pre", 32'(inst_ok_o), 32'd1);
        flush_i    = 1'b1;
        inst_ren_i = 1'b0;
        bus.rvalid = 1'b0;
        #1;
        chk("fld_ok_flush", 32'(inst_ok_o), 32'd0);
        step();
        flush_i = 1'b0;
        #1;
        chk("fld_ok_idle",      32'(inst_ok_o), 32'd0);
        chk("fld_arvalid_idle", 32'(bus.arvalid), 32'd0);

        // flush in IDLE blocks acceptance
        inst_ren_i  = 1'b1;
        inst_addr_i = 32'hBFC0_0000;
        bus.arready = 1'b0;
        flush_i     = 1'b1;
        step();
        chk("fli_arvalid_blocked", 32'(bus.arvalid), 32'd0);
        flush_i = 1'b0;
        step();
        chk("fli_arvalid_accept", 32'(bus.arvalid), 32'd1);

        // reset in the middle of AR
        aresetn = 1'b0;
        #1;
        chk("rstar_arvalid", 32'(bus.arvalid), 32'd0);
        chk("rstar_araddr",  bus.araddr, 32'd0);
        chk("rstar_ok",      32'(inst_ok_o), 32'd0);
        step();
        aresetn     = 1'b1;
        inst_addr_i = 32'hBFC0_0040;
        bus.arready = 1'b1;
        bus.rvalid  = 1'b1;
        bus.rdata   = 32'hCAFE_F00D;
        step();
        chk("rstar_arvalid_c1", 32'(bus.arvalid), 32'd1);
        chk("rstar_araddr_c1",  bus.araddr, 32'hBFC0_0040);
        step();
        chk("rstar_ok_c2", 32'(inst_ok_o), 32'd0);
        step();
        chk("rstar_ok_c3",    32'(inst_ok_o), 32'd1);
        chk("rstar_rdata_c3", inst_rdata_o, 32'hCAFE_F00D);
        chk("rstar_valid_c3", 32'(inst_valid_o), 32'd1);
        inst_ren_i = 1'b0;
        bus.rvalid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
